serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial unsigned subtractor controller: computes diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first.
- Each bit uses two half-subtractor stages plus an OR, with a registered borrow flop carried between bits.
- Start/busy/done handshake lets a host sequence the shared 1-bit subtract datapath.
- Sits between a host FSM and the gate-level half-subtractor cells in the arithmetic library.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); bit counter width = clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while state = RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH
- bor  output  1  final borrow out (1 iff a < b unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on any rising edge with rst=1:
  - state=IDLE; busy=0, done=0, diff=0, bor=0.
  - Internal shift regs, borrow flop and counter all cleared.
  - rst has priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load sa<=a, sb<=b, brw<=0, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN: each edge processes bit i = cnt.
  - Stage 1 (half sub): d1 = sa[0]^sb[0]; b1 = ~sa[0]&sb[0].
  - Stage 2 (half sub): d = d1^brw; b2 = ~d1&brw.
  - Borrow out: bo = b1|b2.
  - Updates: result shift reg sr <= {d, sr[WIDTH-1:1]}; sa, sb shift right by 1; brw <= bo; cnt <= cnt+1.
  - On the edge where cnt = WIDTH-1 (last bit):
    - diff <= final shifted value; bor <= bo.
    - done <= 1; state <= DONE.
- DONE: done is high for exactly this one cycle; next edge sets done<=0 and state<=IDLE.
- busy is combinational from state (RUN only).
- Latency and throughput:
  - Start accepted at edge E0 → done high from edge E0+WIDTH to E0+WIDTH+1.
  - Minimum start-to-start interval is WIDTH+2 cycles. If start is held high continuously, it is re-accepted in the first IDLE cycle.
- Output holding:
  - diff and bor are updated only on the DONE transition.
  - They hold their previous values through a following RUN, until the next completion.
- Operand capture:
  - start is ignored in RUN and DONE, with no queuing.
  - a and b are don't-care except at the accepting edge; changes during RUN do not affect the result.
- Wrap-around: the result is modulo 2^WIDTH. bor reflects the borrow out of the MSB only.
- Reset mid-RUN: the operation is aborted, done never pulses, and diff/bor are cleared to 0.
- Simultaneous rst=1 and start=1: reset wins and start is not accepted.

Test Plan:
- WIDTH=8; rst 2 cycles, then a=100, b=37, start 1 cycle → busy for 8 cycles; done pulses at E0+8; diff=63 (0x3F), bor=0.
- a=5, b=9 → diff=0xFC, bor=1. Also a=0x00, b=0x01 → diff=0xFF, bor=1. Also a=b=0xA5 → diff=0x00, bor=0.
- Assert start with a=200, b=50 during RUN of a prior op (a=10, b=3) → first result diff=7, bor=0; second request is ignored, with no extra done.
- Mid-op input change: change a and b at cycle 3 of RUN → result still matches the values captured at start.
- Mid-op reset: assert rst at cycle 4 of RUN → next cycle busy=0, diff=0, bor=0, no done. A fresh start (a=0xFF, b=0x0F) then yields diff=0xF0, bor=0.
- Back-to-back: hold start=1 for 30 cycles with fixed a=0x80, b=0x01 → done pulses every 10 cycles, diff=0x7F each time, busy low exactly in the DONE and IDLE cycles.

Source files
------------

// File: rtl/serial_sub_ctrl_if.sv
// Host-side bundle for the bit-serial subtractor: request/operands in,
// status/result out.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bor;

  // Host drives the request and operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, bor
  );

  // Subtractor controller consumes the request and produces the result.
  modport slave (
    input  start, a, b,
    output busy, done, diff, bor
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller. Computes a - b one bit per
// clock, LSB first, through two cascaded half subtractors and a borrow flop.
// A start/busy/done handshake sequences the shared 1-bit datapath.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  // Result shift register keeps only the upper WIDTH-1 bits; the bit that
  // would fall off the bottom is never needed because after WIDTH shifts
  // the freshly computed bit plus these bits form the whole result.
  logic [WIDTH-1:1] sr_reg;
  logic             brw_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bor_reg;
  logic             done_reg;

  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             bo;
  logic [WIDTH-1:0] sr_next;

  // One bit of subtraction: two half-subtractor stages joined by an OR.
  always_comb begin
    d1      = sa_reg[0] ^ sb_reg[0];
    b1      = ~sa_reg[0] & sb_reg[0];
    d       = d1 ^ brw_reg;
    b2      = ~d1 & brw_reg;
    bo      = b1 | b2;
    sr_next = {d, sr_reg};
  end

  // Control FSM plus serial datapath registers; result regs change only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sr_reg    <= '0;
      brw_reg   <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bor_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sa_reg    <= bus.a;
            sb_reg    <= bus.b;
            brw_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sr_reg  <= sr_next[WIDTH-1:1];
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          brw_reg <= bo;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            diff_reg  <= sr_next;
            bor_reg   <= bo;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // busy tracks the RUN state directly so the host sees it the same cycle.
  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bor  = bor_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomised and directed bench for serial_sub_ctrl, checked against an
// arithmetic reference model of unsigned modular subtraction.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: difference modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] ref_diff(input int a, input int b);
    return WIDTH'((a - b + (1 << WIDTH)) % (1 << WIDTH));
  endfunction

  // Reference: borrow out of the MSB, i.e. a < b as unsigned numbers.
  function automatic logic ref_bor(input int a, input int b);
    return (a < b);
  endfunction

  // Launch one operation from IDLE and wait (bounded) for its done pulse.
  // Operands are scrambled right after capture. Ends one edge past done.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] got_diff, output logic got_bor,
                       output int lat, output int busy_n, output logic done_after);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    lat       = -1;
    busy_n    = 0;
    got_diff  = 'x;
    got_bor   = 1'bx;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      if (bus.busy === 1'b1) busy_n++;
      step();
      if (bus.done === 1'b1) begin
        lat      = k;
        got_diff = bus.diff;
        got_bor  = bus.bor;
        break;
      end
    end
    step();
    done_after = bus.done;
    $display("op a=%02h b=%02h -> diff=%02h bor=%0b latency=%0d", a, b, got_diff, got_bor, lat);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.diff !== '0)   begin miscompares++; $display("FAIL reset_diff: got %h expected 00", bus.diff); end
    vectors++; if (bus.bor !== 1'b0)  begin miscompares++; $display("FAIL reset_bor: got %b expected 0", bus.bor); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    int ta[5]  = '{100, 5, 'h00, 'hA5, 'hFF};
    int tb_[5] = '{37,  9, 'h01, 'hA5, 'h00};
    int te[5]  = '{63,  'hFC, 'hFF, 'h00, 'hFF};
    int tbo[5] = '{0,   1, 1, 0, 0};
    logic [WIDTH-1:0] gd;
    logic gb, da;
    int lat, bn;
    for (int i = 0; i < 5; i++) begin
      do_op(WIDTH'(ta[i]), WIDTH'(tb_[i]), gd, gb, lat, bn, da);
      vectors++; if (gd !== WIDTH'(te[i])) begin miscompares++; $display("FAIL directed_diff[%0d]: got %h expected %h", i, gd, WIDTH'(te[i])); end
      vectors++; if (gb !== 1'(tbo[i]))    begin miscompares++; $display("FAIL directed_bor[%0d]: got %b expected %0d", i, gb, tbo[i]); end
      vectors++; if (lat != WIDTH)         begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, WIDTH); end
      vectors++; if (bn != WIDTH)          begin miscompares++; $display("FAIL directed_busy_cycles[%0d]: got %0d expected %0d", i, bn, WIDTH); end
      vectors++; if (da !== 1'b0)          begin miscompares++; $display("FAIL directed_done_width[%0d]: got %b expected 0", i, da); end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] gd;
    logic gb, da;
    int lat, bn;
    do_op(8'h33, 8'h11, gd, gb, lat, bn, da);
    vectors++; if (gd !== 8'h22) begin miscompares++; $display("FAIL hold_first_diff: got %h expected 22", gd); end
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy: got %b expected 1", bus.busy); end
    vectors++; if (bus.diff !== 8'h22) begin miscompares++; $display("FAIL hold_diff: got %h expected 22", bus.diff); end
    vectors++; if (bus.bor !== 1'b0)   begin miscompares++; $display("FAIL hold_bor: got %b expected 0", bus.bor); end
    lat = -1;
    for (int k = 4; k <= 3 * WIDTH; k++) begin
      step();
      if (bus.done === 1'b1) begin lat = k; break; end
    end
    vectors++; if (lat != WIDTH)       begin miscompares++; $display("FAIL hold_second_latency: got %0d expected %0d", lat, WIDTH); end
    vectors++; if (bus.diff !== 8'hFF) begin miscompares++; $display("FAIL hold_second_diff: got %h expected ff", bus.diff); end
    vectors++; if (bus.bor !== 1'b1)   begin miscompares++; $display("FAIL hold_second_bor: got %b expected 1", bus.bor); end
    step();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, gd;
    logic gb, da;
    int lat, bn;
    for (int i = 0; i < 24; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (i == 0) a = 8'h00;
      if (i == 1) b = 8'hFF;
      do_op(a, b, gd, gb, lat, bn, da);
      vectors++; if (gd !== ref_diff(int'(a), int'(b))) begin miscompares++; $display("FAIL random_diff[%0d]: got %h expected %h", i, gd, ref_diff(int'(a), int'(b))); end
      vectors++; if (gb !== ref_bor(int'(a), int'(b)))  begin miscompares++; $display("FAIL random_bor[%0d]: got %b expected %b", i, gb, ref_bor(int'(a), int'(b))); end
      vectors++; if (lat != WIDTH) begin miscompares++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, WIDTH); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [WIDTH-1:0] first_diff = 'x;
    logic first_bor = 1'bx;
    bus.start = 1'b1;
    bus.a     = 8'd10;
    bus.b     = 8'd3;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 2 * WIDTH + 4; k++) begin
      if (k == 2) begin bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd50; end
      if (k == 5) bus.start = 1'b0;
      step();
      if (bus.done === 1'b1) begin
        if (ndone == 0) begin first_diff = bus.diff; first_bor = bus.bor; end
        ndone++;
      end
    end
    $display("op a=0a b=03 with start during RUN -> diff=%02h bor=%0b dones=%0d", first_diff, first_bor, ndone);
    vectors++; if (first_diff !== 8'd7) begin miscompares++; $display("FAIL ignore_diff: got %h expected 07", first_diff); end
    vectors++; if (first_bor !== 1'b0)  begin miscompares++; $display("FAIL ignore_bor: got %b expected 0", first_bor); end
    vectors++; if (ndone != 1)          begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    vectors++; if (bus.diff !== 8'd7)   begin miscompares++; $display("FAIL ignore_final_diff: got %h expected 07", bus.diff); end
  endtask

  task automatic test_midop_change();
    logic [WIDTH-1:0] a, b;
    int lat = -1;
    for (int i = 0; i < 4; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      step();
      bus.start = 1'b0;
      lat       = -1;
      for (int k = 1; k <= 3 * WIDTH; k++) begin
        if (k == 3) begin bus.a = ~a; bus.b = a ^ b ^ 8'h5A; end
        step();
        if (bus.done === 1'b1) begin lat = k; break; end
      end
      $display("op a=%02h b=%02h (changed mid-run) -> diff=%02h bor=%0b", a, b, bus.diff, bus.bor);
      vectors++; if (lat != WIDTH) begin miscompares++; $display("FAIL midchange_latency[%0d]: got %0d expected %0d", i, lat, WIDTH); end
      vectors++; if (bus.diff !== ref_diff(int'(a), int'(b))) begin miscompares++; $display("FAIL midchange_diff[%0d]: got %h expected %h", i, bus.diff, ref_diff(int'(a), int'(b))); end
      vectors++; if (bus.bor !== ref_bor(int'(a), int'(b)))   begin miscompares++; $display("FAIL midchange_bor[%0d]: got %b expected %b", i, bus.bor, ref_bor(int'(a), int'(b))); end
      step();
    end
  endtask

  task automatic test_midop_reset();
    logic [WIDTH-1:0] gd;
    logic gb, da;
    int lat, bn;
    int ndone = 0;
    do_op(8'h01, 8'h02, gd, gb, lat, bn, da);
    vectors++; if (gb !== 1'b1) begin miscompares++; $display("FAIL midreset_pre_bor: got %b expected 1", gb); end
    bus.start = 1'b1;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    step();
    bus.start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("op aborted by reset -> busy=%0b diff=%02h bor=%0b", bus.busy, bus.diff, bus.bor);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.diff !== '0)   begin miscompares++; $display("FAIL midreset_diff: got %h expected 00", bus.diff); end
    vectors++; if (bus.bor !== 1'b0)  begin miscompares++; $display("FAIL midreset_bor: got %b expected 0", bus.bor); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
    for (int k = 0; k < 2 * WIDTH; k++) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
    end
    vectors++; if (ndone != 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", ndone); end
    do_op(8'hFF, 8'h0F, gd, gb, lat, bn, da);
    vectors++; if (gd !== 8'hF0) begin miscompares++; $display("FAIL midreset_fresh_diff: got %h expected f0", gd); end
    vectors++; if (gb !== 1'b0)  begin miscompares++; $display("FAIL midreset_fresh_bor: got %b expected 0", gb); end
    vectors++; if (lat != WIDTH) begin miscompares++; $display("FAIL midreset_fresh_latency: got %0d expected %0d", lat, WIDTH); end
  endtask

  task automatic test_rst_start();
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    $display("op rst with start -> busy=%0b", bus.busy);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy: got %b expected 0", bus.busy); end
    step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy_next: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic exp_busy, exp_done;
    bus.start = 1'b1;
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    // Period of WIDTH+2: WIDTH busy cycles, then DONE, then IDLE.
    for (int c = 1; c <= 32; c++) begin
      step();
      exp_busy = ((c - 1) % (WIDTH + 2)) < WIDTH;
      exp_done = ((c - 1) % (WIDTH + 2)) == WIDTH;
      vectors++; if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL b2b_busy[c%0d]: got %b expected %b", c, bus.busy, exp_busy); end
      vectors++; if (bus.done !== exp_done) begin miscompares++; $display("FAIL b2b_done[c%0d]: got %b expected %b", c, bus.done, exp_done); end
      if (exp_done) begin
        ndone++;
        $display("op a=80 b=01 back-to-back #%0d -> diff=%02h bor=%0b", ndone, bus.diff, bus.bor);
        vectors++; if (bus.diff !== 8'h7F) begin miscompares++; $display("FAIL b2b_diff[c%0d]: got %h expected 7f", c, bus.diff); end
        vectors++; if (bus.bor !== 1'b0)   begin miscompares++; $display("FAIL b2b_bor[c%0d]: got %b expected 0", c, bus.bor); end
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < WIDTH + 4; c++) step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_ignore_start();
    test_midop_change();
    test_midop_reset();
    test_rst_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
